// File: rtl/midi_pkg.sv
// Shared MIDI constants, burst slot word layout and the midi_burst FSM/operation types.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] CTRL             = 4'hB;
  localparam logic [7:0] CC_ALL_NOTES_OFF = 8'd123;

  localparam int CNT_W = 3;

  localparam int WORD_STATUS_LSB = 24;
  localparam int WORD_NOTE_LSB   = 8;
  localparam int WORD_VEL_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MATCH   = 3'd1,
    ST_COMPACT = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_APPEND = 3'd1,
    OP_REMOVE = 3'd2,
    OP_STEAL  = 3'd3,
    OP_CLEAR  = 3'd4
  } op_t;

  function automatic logic [31:0] make_word(input logic [3:0] channel,
                                            input logic [7:0] note,
                                            input logic [7:0] vel);
    logic [31:0] w;
    w = '0;
    w[WORD_STATUS_LSB +: 8] = {NOTE_ON, channel};
    w[WORD_NOTE_LSB +: 8]   = note;
    w[WORD_VEL_LSB +: 8]    = vel;
    return w;
  endfunction

endpackage

// File: rtl/midi_slot_match.sv
// Parallel note comparator over the occupied slots; reports a hit and the lowest matching index.
module midi_slot_match
  import midi_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int IW        = 3
) (
  input  logic [7:0]       notes [NUM_SLOTS],
  input  logic [CNT_W-1:0] count,
  input  logic [7:0]       note,
  output logic             hit,
  output logic [IW-1:0]    idx
);

  // Scanning from the top down lets the lowest matching slot win.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if ((i < int'(count)) && (notes[i] == note)) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/midi_burst.sv
// Active-note slot table publishing burst snapshots to pwm_combine.
// Define MIDI_BURST_STEAL_EN to evict the oldest note when a note-on hits a full table.
module midi_burst
  import midi_pkg::*;
#(
  parameter int         NUM_SLOTS = 5,
  parameter logic [3:0] CHANNEL   = 4'd0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   msg_valid_in,
  output logic                   msg_ready_out,
  input  logic [7:0]             msg_status_in,
  input  logic [7:0]             msg_data1_in,
  input  logic [7:0]             msg_data2_in,
  output logic                   midi_burst_ready_out,
  output logic [CNT_W-1:0]       on_msg_count_out,
  output logic [31:0]            midi_burst_data_out [NUM_SLOTS],
  output logic                   overflow_out,
  output logic [2:0]             fsm_state_out
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SLOTS);

  // Handshake: a message transfers on a rising edge where msg_valid_in and
  // msg_ready_out are both high; ready is only asserted in IDLE out of reset.

  state_t           state;
  op_t              op;
  logic [31:0]      tbl     [NUM_SLOTS];
  logic [31:0]      tbl_nxt [NUM_SLOTS];
  logic [7:0]       notes   [NUM_SLOTS];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       m_status;
  logic [7:0]       m_note;
  logic [7:0]       m_vel;
  logic [IW-1:0]    h;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    last_idx;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             on_ch;
  logic             is_on;
  logic             is_off;
  logic             is_clear;

  assign msg_ready_out = rst_in && (state == ST_IDLE);
  assign fsm_state_out = state;
  assign last_idx      = IW'(cnt - 1'b1);

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) notes[i] = tbl[i][WORD_NOTE_LSB +: 8];
  end

  midi_slot_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .IW        (IW)
  ) u_match (
    .notes (notes),
    .count (cnt),
    .note  (m_note),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign on_ch    = (m_status[3:0] == CHANNEL);
  assign is_on    = on_ch && (m_status[7:4] == NOTE_ON) && (m_vel != 8'd0);
  assign is_off   = on_ch && ((m_status[7:4] == NOTE_OFF) ||
                              ((m_status[7:4] == NOTE_ON) && (m_vel == 8'd0)));
  assign is_clear = on_ch && (m_status[7:4] == CTRL) && (m_note == CC_ALL_NOTES_OFF);

  // Final table contents after the pending operation; any compaction is already done.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) tbl_nxt[i] = tbl[i];
    cnt_nxt = cnt;
    case (op)
      OP_WRITE:  tbl_nxt[h][WORD_VEL_LSB +: 8] = m_vel;
      OP_APPEND: begin
        tbl_nxt[IW'(cnt)] = make_word(CHANNEL, m_note, m_vel);
        cnt_nxt           = cnt + 1'b1;
      end
      OP_REMOVE: begin
        tbl_nxt[last_idx] = '0;
        cnt_nxt           = cnt - 1'b1;
      end
      OP_STEAL:  tbl_nxt[IW'(NUM_SLOTS - 1)] = make_word(CHANNEL, m_note, m_vel);
      OP_CLEAR: begin
        for (int i = 0; i < NUM_SLOTS; i++) tbl_nxt[i] = '0;
        cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                <= ST_IDLE;
      op                   <= OP_WRITE;
      cnt                  <= '0;
      m_status             <= '0;
      m_note               <= '0;
      m_vel                <= '0;
      h                    <= '0;
      ptr                  <= '0;
      midi_burst_ready_out <= 1'b0;
      on_msg_count_out     <= '0;
      overflow_out         <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tbl[i]                 <= '0;
        midi_burst_data_out[i] <= '0;
      end
    end else begin
      midi_burst_ready_out <= 1'b0;
      overflow_out         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (msg_valid_in && msg_ready_out) begin
            m_status <= msg_status_in;
            m_note   <= msg_data1_in;
            m_vel    <= msg_data2_in;
            state    <= ST_MATCH;
          end
        end
        ST_MATCH: begin
          state <= ST_IDLE;
          h     <= hit_idx;
          ptr   <= hit_idx;
          if (is_on) begin
            if (hit) begin
              op    <= OP_WRITE;
              state <= ST_UPDATE;
            end else if (cnt < FULL) begin
              op    <= OP_APPEND;
              state <= ST_UPDATE;
            end else begin
              overflow_out <= 1'b1;
`ifdef MIDI_BURST_STEAL_EN
              // Evict the oldest note by compacting from slot 0, then append at the top.
              op    <= OP_STEAL;
              ptr   <= '0;
              state <= (last_idx != '0) ? ST_COMPACT : ST_UPDATE;
`endif
            end
          end else if (is_off && hit) begin
            op    <= OP_REMOVE;
            state <= (hit_idx < last_idx) ? ST_COMPACT : ST_UPDATE;
          end else if (is_clear) begin
            op    <= OP_CLEAR;
            state <= ST_UPDATE;
          end
        end
        ST_COMPACT: begin
          tbl[ptr] <= tbl[ptr + 1'b1];
          if (ptr == last_idx - 1'b1) state <= ST_UPDATE;
          else                        ptr   <= ptr + 1'b1;
        end
        ST_UPDATE: begin
          tbl                  <= tbl_nxt;
          cnt                  <= cnt_nxt;
          midi_burst_data_out  <= tbl_nxt;
          on_msg_count_out     <= cnt_nxt;
          midi_burst_ready_out <= 1'b1;
          state                <= ST_EMIT;
        end
        ST_EMIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_burst.sv
// Self-checking bench for midi_burst: directed vector table, corner sequences, random vs. queue model.
module tb_midi_burst;
  import midi_pkg::*;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  status, d1, d2;
  logic        msg_ready, burst_ready, ov;
  logic [2:0]  cnt, st;
  logic [31:0] data [N];

  always #5 clk = ~clk;

  midi_burst #(.NUM_SLOTS(N), .CHANNEL(4'd0)) dut (
    .clk_in               (clk),
    .rst_in               (rst_n),
    .msg_valid_in         (valid),
    .msg_ready_out        (msg_ready),
    .msg_status_in        (status),
    .msg_data1_in         (d1),
    .msg_data2_in         (d2),
    .midi_burst_ready_out (burst_ready),
    .on_msg_count_out     (cnt),
    .midi_burst_data_out  (data),
    .overflow_out         (ov),
    .fsm_state_out        (st)
  );

  int total = 0;
  int bad   = 0;

  typedef logic [31:0] slots_t [N];
  typedef struct {
    logic [7:0] s, d1, d2;
    bit         burst, ov;
    int         lat;
    int         cnt;
    slots_t     sl;
  } vec_t;

  vec_t        tv [18];
  logic [15:0] mq [$];   // reference model: {note, velocity} in arrival order

  int r_rdy, r_ov, r_idle, r_pulses;
  bit r_to;

  function automatic logic [31:0] w(input logic [7:0] note, input logic [7:0] vel);
    return 32'h9000_0000 | (32'(note) << 8) | 32'(vel);
  endfunction

  function automatic vec_t row(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                               input bit eb, input bit eo, input int lat, input int c,
                               input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] s3, input logic [31:0] s4);
    vec_t v;
    v.s = s; v.d1 = a; v.d2 = b; v.burst = eb; v.ov = eo; v.lat = lat; v.cnt = c;
    v.sl[0] = s0; v.sl[1] = s1; v.sl[2] = s2; v.sl[3] = s3; v.sl[4] = s4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents one message at a negedge, then watches the cycles after the transfer edge.
  task automatic send(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    while (!msg_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    status = s; d1 = a; d2 = b; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    r_rdy = 0; r_ov = 0; r_idle = 0; r_pulses = 0; r_to = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (burst_ready) begin r_rdy = n; r_pulses++; end
      if (ov) r_ov = n;
      if (msg_ready) begin
        r_idle = n;
        r_to   = 1'b0;
        break;
      end
    end
  endtask

  task automatic apply_check(input string tag, input logic [7:0] s, input logic [7:0] a,
                             input logic [7:0] b, input bit eb, input bit eo, input int elat,
                             input int ecnt, input slots_t esl);
    send(s, a, b);
    chk({tag, " timeout"}, 32'(r_to), 32'd0);
    chk({tag, " ready_cycle"}, r_rdy, eb ? elat : 0);
    chk({tag, " pulses"}, r_pulses, eb ? 1 : 0);
    chk({tag, " overflow_cycle"}, r_ov, eo ? 2 : 0);
    chk({tag, " idle_cycle"}, r_idle, eb ? elat + 1 : 2);
    chk({tag, " count"}, 32'(cnt), ecnt);
    for (int i = 0; i < N; i++) chk($sformatf("%s slot%0d", tag, i), data[i], esl[i]);
  endtask

  // Behavioural model: list semantics of the active-note set.
  task automatic model_step(input string tag, input logic [7:0] s, input logic [7:0] a,
                            input logic [7:0] b);
    bit     eb = 1'b0;
    bit     eo = 1'b0;
    int     elat = 0;
    int     hit = -1;
    slots_t esl;
    for (int i = 0; i < mq.size(); i++) if (hit < 0 && mq[i][15:8] == a) hit = i;
    if (s[3:0] == 4'h0) begin
      if (s[7:4] == 4'h9 && b != 8'd0) begin
        if (hit >= 0) begin
          mq[hit] = {a, b}; eb = 1'b1; elat = 3;
        end else if (mq.size() < N) begin
          mq.push_back({a, b}); eb = 1'b1; elat = 3;
        end else begin
          eo = 1'b1;
`ifdef MIDI_BURST_STEAL_EN
          void'(mq.pop_front());
          mq.push_back({a, b});
          eb = 1'b1; elat = 3 + (N - 1);
`endif
        end
      end else if (s[7:4] == 4'h8 || s[7:4] == 4'h9) begin
        if (hit >= 0) begin
          elat = 3 + (mq.size() - 1 - hit);
          mq.delete(hit);
          eb = 1'b1;
        end
      end else if (s[7:4] == 4'hB && a == 8'd123) begin
        mq.delete(); eb = 1'b1; elat = 3;
      end
    end
    for (int i = 0; i < N; i++) esl[i] = (i < mq.size()) ? w(mq[i][15:8], mq[i][7:0]) : 32'd0;
    apply_check(tag, s, a, b, eb, eo, elat, mq.size(), esl);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mq.delete();
  endtask

  task automatic load_60_64();
    for (int i = 0; i < N; i++) model_step("load", 8'h90, 8'(60 + i), 8'h64);
  endtask

  logic [31:0] A, B, C, D, E, Z;
  slots_t      esl;

  initial begin
    rst_n = 1'b0; valid = 1'b0; status = '0; d1 = '0; d2 = '0;
    A = w(8'h3C, 8'h64); B = w(8'h3D, 8'h40); C = w(8'h3E, 8'h40);
    D = w(8'h3F, 8'h40); E = w(8'h40, 8'h40); Z = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset msg_ready", 32'(msg_ready), 32'd0);
    chk("reset burst_ready", 32'(burst_ready), 32'd0);
    chk("reset overflow", 32'(ov), 32'd0);
    chk("reset count", 32'(cnt), 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("reset slot%0d", i), data[i], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release msg_ready", 32'(msg_ready), 32'd1);

    tv[0]  = row(8'h90, 8'h3C, 8'h64, 1, 0, 3, 1, A, Z, Z, Z, Z);
    tv[1]  = row(8'h90, 8'h3D, 8'h40, 1, 0, 3, 2, A, B, Z, Z, Z);
    tv[2]  = row(8'h90, 8'h3E, 8'h40, 1, 0, 3, 3, A, B, C, Z, Z);
    tv[3]  = row(8'h90, 8'h3F, 8'h40, 1, 0, 3, 4, A, B, C, D, Z);
    tv[4]  = row(8'h90, 8'h40, 8'h40, 1, 0, 3, 5, A, B, C, D, E);
    tv[5]  = row(8'h90, 8'h3E, 8'h40, 1, 0, 3, 5, A, B, C, D, E);
    tv[6]  = row(8'h80, 8'h45, 8'h00, 0, 0, 0, 5, A, B, C, D, E);
    tv[7]  = row(8'h91, 8'h3C, 8'h64, 0, 0, 0, 5, A, B, C, D, E);
    tv[8]  = row(8'hA0, 8'h3C, 8'h64, 0, 0, 0, 5, A, B, C, D, E);
    tv[9]  = row(8'h90, 8'h3C, 8'h00, 1, 0, 7, 4, B, C, D, E, Z);
    tv[10] = row(8'h90, 8'h3C, 8'h64, 1, 0, 3, 5, B, C, D, E, A);
`ifdef MIDI_BURST_STEAL_EN
    tv[11] = row(8'h90, 8'h41, 8'h50, 1, 1, 7, 5, C, D, E, A, w(8'h41, 8'h50));
`else
    tv[11] = row(8'h90, 8'h41, 8'h50, 0, 1, 0, 5, B, C, D, E, A);
`endif
    tv[12] = row(8'hB0, 8'h7B, 8'h00, 1, 0, 3, 0, Z, Z, Z, Z, Z);
    tv[13] = row(8'hB0, 8'h7B, 8'h00, 1, 0, 3, 0, Z, Z, Z, Z, Z);
    tv[14] = row(8'hB0, 8'h07, 8'h00, 0, 0, 0, 0, Z, Z, Z, Z, Z);
    tv[15] = row(8'h80, 8'h3C, 8'h00, 0, 0, 0, 0, Z, Z, Z, Z, Z);
    tv[16] = row(8'h90, 8'h3C, 8'h64, 1, 0, 3, 1, A, Z, Z, Z, Z);
    tv[17] = row(8'h80, 8'h3C, 8'h00, 1, 0, 3, 0, Z, Z, Z, Z, Z);

    for (int i = 0; i < 18; i++)
      apply_check($sformatf("vec%0d", i), tv[i].s, tv[i].d1, tv[i].d2, tv[i].burst,
                   tv[i].ov, tv[i].lat, tv[i].cnt, tv[i].sl);

    // Removal from the middle of a full table: two compaction cycles.
    do_reset();
    load_60_64();
    esl[0] = w(8'h3C, 8'h64); esl[1] = w(8'h3D, 8'h64); esl[2] = w(8'h3F, 8'h64);
    esl[3] = w(8'h40, 8'h64); esl[4] = 32'd0;
    apply_check("mid_remove", 8'h80, 8'h3E, 8'h00, 1, 0, 5, 4, esl);

    // Reset landing in the middle of compaction.
    do_reset();
    load_60_64();
    begin
      int guard = 0;
      int pulses = 0;
      while (!msg_ready && guard < 50) begin @(negedge clk); guard++; end
      status = 8'h80; d1 = 8'h3C; d2 = 8'h00; valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort in_compact", 32'(st), 32'(ST_COMPACT));
      rst_n = 1'b0;
      @(negedge clk);
      if (burst_ready) pulses++;
      chk("abort count", 32'(cnt), 32'd0);
      chk("abort msg_ready_in_reset", 32'(msg_ready), 32'd0);
      chk("abort state", 32'(st), 32'(ST_IDLE));
      for (int i = 0; i < N; i++) chk($sformatf("abort slot%0d", i), data[i], 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort msg_ready_after", 32'(msg_ready), 32'd1);
      repeat (6) begin
        @(negedge clk);
        if (burst_ready) pulses++;
      end
      chk("abort no_burst", pulses, 0);
      mq.delete();
    end

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 250; k++) begin
      int          r;
      logic [7:0]  s, a, b;
      r = $urandom_range(0, 9);
      a = 8'(60 + $urandom_range(0, 6));
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
      if (r <= 4)      s = 8'h90;
      else if (r <= 7) s = 8'h80;
      else if (r == 8) begin
        s = 8'hB0;
        a = ($urandom_range(0, 1) == 0) ? 8'd123 : 8'($urandom_range(0, 127));
      end else begin
        s = ($urandom_range(0, 1) == 0) ? 8'h91 : 8'hE0;
      end
      model_step($sformatf("rnd%0d", k), s, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
